mem_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch port and its data (load/store) port. It replaces the split instruction/data memories when the core is wired to one physical RAM. The arbiter accepts one transaction at a time, issues it to the memory, waits a fixed latency and returns the response to the owner. Data requests have priority, and a bounded-starvation rule guarantees fetch progress.

---
 rtl/types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared core types: datapath width plus the state and owner encodings used by the
// unified-memory arbiter.
package types_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports. It runs one
// transaction at a time, gives data priority, and bounds how long fetch can be starved.
module mem_arbiter
    import types_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int BE_W     = XLEN / 8;
    localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    mem_arb_state_t        state, nextState;
    mem_arb_owner_t        owner;
    logic [XLEN-1:0]       addrQ, wdataQ, ifRdataQ, dRdataQ;
    logic [BE_W-1:0]       beQ;
    logic                  weQ;
    logic [LAT_W-1:0]      latCnt;
    logic [STARVE_W-1:0]   starveCnt;
    logic                  anyReq, grantIf, accept;

    // Fetch only wins over a competing data request once data has used up its quota.
    always_comb begin
        anyReq  = if_req | d_req;
        grantIf = if_req & (~d_req | (starveCnt == STARVE_MAX));
        accept  = anyReq & ((state == IDLE) | (state == RESP));
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT:    if (latCnt == '0) nextState = RESP;
            RESP:    nextState = anyReq ? ISSUE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The latched request and the per-port read-data registers are
    // cleared by reset, so the memory bus and rdata outputs read 0 until
    // the first grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_IF;
            addrQ     <= '0;
            wdataQ    <= '0;
            beQ       <= '0;
            weQ       <= 1'b0;
            latCnt    <= '0;
            starveCnt <= '0;
            ifRdataQ  <= '0;
            dRdataQ   <= '0;
        end else begin
            if (accept) begin
                owner <= grantIf ? OWN_IF : OWN_D;
                addrQ <= grantIf ? if_addr : d_addr;
                weQ   <= grantIf ? 1'b0 : d_we;
                beQ   <= grantIf ? {BE_W{1'b1}} : d_be;
                if (!grantIf) begin
                    wdataQ <= d_wdata;
                end
            end
            if (state == ISSUE) begin
                latCnt <= LAT_INIT;
                if ((owner == OWN_IF) || !if_req) begin
                    starveCnt <= '0;
                end else if (starveCnt != STARVE_MAX) begin
                    starveCnt <= starveCnt + 1'b1;
                end
            end
            if (state == WAIT) begin
                if (latCnt == '0) begin
                    if (owner == OWN_IF) begin
                        ifRdataQ <= mem_rdata;
                    end else begin
                        dRdataQ <= weQ ? '0 : mem_rdata;
                    end
                end else begin
                    latCnt <= latCnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_en    = (state == ISSUE);
        mem_we    = mem_en & weQ;
        mem_addr  = addrQ;
        mem_wdata = wdataQ;
        mem_be    = beQ;
        if_gnt    = mem_en & (owner == OWN_IF);
        d_gnt     = mem_en & (owner == OWN_D);
        if_rvalid = (state == RESP) & (owner == OWN_IF);
        d_rvalid  = (state == RESP) & (owner == OWN_D);
        if_rdata  = ifRdataQ;
        d_rdata   = dRdataQ;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It pairs a behavioural memory model with a table of
// single-owner transactions, plus hand sequences for contention, starvation and reset.
module tb_mem_arbiter;
    import types_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req, d_req, d_we;
    logic [XLEN-1:0]   if_addr, d_addr, d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [XLEN-1:0]   if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        isFetch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  expBe;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [0:7];

    mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory whose read data is valid only during the cycle two after the
    // mem_en cycle. Any other cycle shows a poison pattern.
    logic [31:0] memArray [0:255];
    logic        pipeValid = 1'b0;
    logic [31:0] pipeData  = '0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pipeValid <= mem_en;
        pipeData  <= memArray[mem_addr[9:2]];
        mem_rdata <= pipeValid ? pipeData : 32'hBADB_AD00;
        if (mem_en && mem_we) begin
            memArray[mem_addr[9:2]] <= mergeBytes(memArray[mem_addr[9:2]], mem_wdata, mem_be);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " if_gnt"}, {31'b0, if_gnt}, 32'h0);
        checkOutput({tag, " d_gnt"}, {31'b0, d_gnt}, 32'h0);
        checkOutput({tag, " if_rvalid"}, {31'b0, if_rvalid}, 32'h0);
        checkOutput({tag, " d_rvalid"}, {31'b0, d_rvalid}, 32'h0);
        checkOutput({tag, " mem_en"}, {31'b0, mem_en}, 32'h0);
        checkOutput({tag, " mem_we"}, {31'b0, mem_we}, 32'h0);
        checkOutput({tag, " mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, " mem_be"}, {28'b0, mem_be}, 32'h0);
        checkOutput({tag, " if_rdata"}, if_rdata, 32'h0);
        checkOutput({tag, " d_rdata"}, d_rdata, 32'h0);
    endtask

    // Runs one transaction from IDLE and returns five cycles later, with the arbiter idle again.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if_req  = v.isFetch;
        if_addr = v.addr;
        d_req   = ~v.isFetch;
        d_we    = v.we;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        d_be    = v.be;
        @(negedge clk);
        checkOutput({tag, " if_gnt"}, {31'b0, if_gnt}, {31'b0, v.isFetch});
        checkOutput({tag, " d_gnt"}, {31'b0, d_gnt}, {31'b0, ~v.isFetch});
        checkOutput({tag, " mem_en"}, {31'b0, mem_en}, 32'h1);
        checkOutput({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, v.we & ~v.isFetch});
        checkOutput({tag, " mem_addr"}, mem_addr, v.addr);
        checkOutput({tag, " mem_be"}, {28'b0, mem_be}, {28'b0, v.expBe});
        if (!v.isFetch) checkOutput({tag, " mem_wdata"}, mem_wdata, v.wdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        checkOutput({tag, " mem_en low"}, {31'b0, mem_en}, 32'h0);
        checkOutput({tag, " mem_we low"}, {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        checkOutput({tag, " early rvalid"}, {30'b0, if_rvalid, d_rvalid}, 32'h0);
        @(negedge clk);
        if (v.isFetch) begin
            checkOutput({tag, " if_rvalid"}, {31'b0, if_rvalid}, 32'h1);
            checkOutput({tag, " d_rvalid"}, {31'b0, d_rvalid}, 32'h0);
            checkOutput({tag, " if_rdata"}, if_rdata, v.expRdata);
        end else begin
            checkOutput({tag, " d_rvalid"}, {31'b0, d_rvalid}, 32'h1);
            checkOutput({tag, " if_rvalid"}, {31'b0, if_rvalid}, 32'h0);
            checkOutput({tag, " d_rdata"}, d_rdata, v.expRdata);
        end
        @(negedge clk);
        checkOutput({tag, " rvalid drop"}, {30'b0, if_rvalid, d_rvalid}, 32'h0);
    endtask

    initial begin
        int nGnt;
        logic gntIsFetch [0:9];
        int   gntCycle   [0:9];

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

        //              fetch we    addr          wdata          be    expBe  expRdata
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0050_0093, 4'hF, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 4'hF, 32'h0050_0093};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 4'hF, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0104, 32'hAABB_CCDD, 4'hF, 4'hF, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'h2, 4'h2, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'hF, 4'hF, 32'hAABB_33DD};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 4'hF, 32'hAABB_33DD};

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);
        checkOutput("d_rdata hold across fetch", d_rdata, 32'hAABB_33DD);

        // Simultaneous requests: data first, fetch follows straight out of RESP.
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        @(negedge clk);
        checkOutput("both d_gnt", {31'b0, d_gnt}, 32'h1);
        checkOutput("both if_gnt wait", {31'b0, if_gnt}, 32'h0);
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("both d_rvalid", {31'b0, d_rvalid}, 32'h1);
        checkOutput("both d_rdata", d_rdata, 32'hDEAD_BEEF);
        checkOutput("both if_gnt still low", {31'b0, if_gnt}, 32'h0);
        @(negedge clk);
        checkOutput("both if_gnt", {31'b0, if_gnt}, 32'h1);
        checkOutput("both if mem_addr", mem_addr, 32'h10);
        checkOutput("both if mem_we", {31'b0, mem_we}, 32'h0);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("both if_rvalid", {31'b0, if_rvalid}, 32'h1);
        checkOutput("both if_rdata", if_rdata, 32'h0050_0093);
        checkOutput("both d_rdata hold", d_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Both ports held continuously: fetch must get every fifth grant.
        nGnt = 0;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        for (int c = 1; c <= 60 && nGnt < 10; c++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                gntIsFetch[nGnt] = if_gnt;
                gntCycle[nGnt]   = c;
                nGnt++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checkOutput("starve grant count", nGnt, 10);
        for (int i = 0; i < nGnt; i++) begin
            checkOutput($sformatf("starve owner%0d", i), {31'b0, gntIsFetch[i]},
                        (i == 4 || i == 9) ? 32'h1 : 32'h0);
            if (i > 0) checkOutput($sformatf("starve spacing%0d", i),
                                   gntCycle[i] - gntCycle[i-1], 32'd4);
        end
        repeat (6) @(negedge clk);

        // Reset during WAIT of a load discards it entirely.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        @(negedge clk);
        checkOutput("rst d_gnt", {31'b0, d_gnt}, 32'h1);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("no stale d_rvalid c%0d", c), {31'b0, d_rvalid}, 32'h0);
        end
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        checkOutput("post-reset if_gnt", {31'b0, if_gnt}, 32'h1);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post-reset if_rvalid", {31'b0, if_rvalid}, 32'h1);
        checkOutput("post-reset if_rdata", if_rdata, 32'h0050_0093);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
